// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the ram512_arbiter slice.
//   - FSM state encoding (IDLE/ACCESS/DONE)
//   - default address/data widths
//   - requester port identifiers
package ram_arb_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/ram512_arbiter_if.sv
// ram512_arbiter_if: requester-side bundle of the two-port RAM arbiter.
//   Per port n in {0,1}: reqn, wen, addrn, wdatan (requester -> arbiter),
//   ackn, rdatan (arbiter -> requester).
//   modport master: the requesters; modport slave: the arbiter.
interface ram512_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
) ();
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/ram_arb_pick2.sv
// ram_arb_pick2: combinational two-way request picker.
//   in : req0, req1, last_grant (port id granted most recently)
//   out: grant_valid (any request), grant_id (winning port)
//   Config macro RAM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a
//   tie; otherwise a tie goes to the port that did not win last time.
module ram_arb_pick2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    // last_grant is kept on the port list for drop-in compatibility only
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Winner selection for the current request pattern
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = P0;
        case ({req1, req0})
            2'b01:   grant_id = P0;
            2'b10:   grant_id = P1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            2'b11:   grant_id = P0;
`else
            2'b11:   grant_id = (last_grant == P0) ? P1 : P0;
`endif
            default: grant_id = P0;
        endcase
    end

endmodule

// File: rtl/ram512_arbiter.sv
// ram512_arbiter: arbiter and sequencer for a single-port 512 x 16 RAM.
//   clk, rst_n        : clock (shared with the RAM), async active-low reset
//   bus (slave)       : two requester ports, req/ack handshake, rdata per port
//   ram_sel/ram_in    : registered RAM address / write data
//   ram_load          : RAM write enable, high only in ACCESS of a write
//   ram_out           : combinational RAM read data
//   busy              : high in ACCESS and DONE
//   Every access takes IDLE -> ACCESS -> DONE (3 cycles). Tie policy is set
//   by RAM_ARB_FIXED_PRIO_EN inside ram_arb_pick2 (round-robin by default).
module ram512_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    ram512_arbiter_if.slave bus,
    output logic [AW-1:0] ram_sel,
    output logic [DW-1:0] ram_in,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out,
    output logic          busy
);

    logic [1:0]    state_r;
    logic          we_r;
    logic          id_r;
    logic          last_grant_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          ack0_r;
    logic          ack1_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;

    logic          grant_valid_s;
    logic          grant_id_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    ram_arb_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Command fields of whichever port the picker selected
    always_comb begin
        win_we_s    = bus.we0;
        win_addr_s  = bus.addr0;
        win_wdata_s = bus.wdata0;
        if (grant_id_s == P1) begin
            win_we_s    = bus.we1;
            win_addr_s  = bus.addr1;
            win_wdata_s = bus.wdata1;
        end else begin
            win_we_s    = bus.we0;
            win_addr_s  = bus.addr0;
            win_wdata_s = bus.wdata0;
        end
    end

    // FSM, command registers, ack pulses and per-port read data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            id_r         <= P0;
            last_grant_r <= P1;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata0_r     <= {DW{1'b0}};
            rdata1_r     <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (grant_valid_s) begin
                        // addr_r/wdata_r double as ram_sel/ram_in, so they
                        // only change here and hold between accesses
                        we_r         <= win_we_s;
                        addr_r       <= win_addr_s;
                        wdata_r      <= win_wdata_s;
                        id_r         <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        state_r      <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!we_r) begin
                        if (id_r == P1) begin
                            rdata1_r <= ram_out;
                        end else begin
                            rdata0_r <= ram_out;
                        end
                    end
                    // ack is registered here so it is visible during DONE
                    ack0_r  <= (id_r == P0);
                    ack1_r  <= (id_r == P1);
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // State decode for the write strobe and busy flag; reset clears both at once
    always_comb begin
        ram_load = 1'b0;
        busy     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ram_load = 1'b0;
                busy     = 1'b0;
            end
            ST_ACCESS: begin
                ram_load = we_r;
                busy     = 1'b1;
            end
            ST_DONE: begin
                ram_load = 1'b0;
                busy     = 1'b1;
            end
            default: begin
                ram_load = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign ram_sel    = addr_r;
    assign ram_in     = wdata_r;
    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.rdata0 = rdata0_r;
    assign bus.rdata1 = rdata1_r;

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb_ram512_arbiter: self-checking bench for ram512_arbiter.
//   Holds a 512 x 16 RAM model on the ram_* lines and a reference model
//   (memory array, last winner, expected rdata per port, command queues).
module tb_ram512_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_sel;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;
    logic          ram_load;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem     [0:511];
    logic [DW-1:0] ref_mem [0:511];
    logic [DW-1:0] exp_rdata0;
    logic [DW-1:0] exp_rdata1;
    bit            exp_last;
    cmd_t          q0[$];
    cmd_t          q1[$];
    int            grants[$];

    ram512_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram512_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .ram_sel  (ram_sel),
        .ram_in   (ram_in),
        .ram_load (ram_load),
        .ram_out  (ram_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, synchronous write
    assign ram_out = mem[ram_sel];
    always @(posedge clk) begin
        if (ram_load) mem[ram_sel] <= ram_in;
    end

    // Tie-break rule of the arbiter
    function automatic bit pick(bit r0, bit r1, bit last);
        if (r0 && !r1) return 1'b0;
        if (r1 && !r0) return 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~last;
`endif
    endfunction

    function automatic cmd_t mk(bit we, int addr, int data);
        cmd_t c;
        c.we   = we;
        c.addr = addr[AW-1:0];
        c.data = data[DW-1:0];
        return c;
    endfunction

    // Serve everything in q0/q1, checking each access cycle by cycle
    task automatic run_queues();
        cmd_t c0, c1, c;
        bit   w;
        int   guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
            guard++;
            c0 = (q0.size() > 0) ? q0[0] : cmd_t'(0);
            c1 = (q1.size() > 0) ? q1[0] : cmd_t'(0);
            bus.req0 = (q0.size() > 0); bus.we0 = c0.we; bus.addr0 = c0.addr; bus.wdata0 = c0.data;
            bus.req1 = (q1.size() > 0); bus.we1 = c1.we; bus.addr1 = c1.addr; bus.wdata1 = c1.data;
            w = pick(q0.size() > 0, q1.size() > 0, exp_last);
            c = w ? c1 : c0;
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({busy, bus.ack1, bus.ack0, ram_load, ram_sel, ram_in} !== {1'b1, 1'b0, 1'b0, c.we, c.addr, c.data}) begin
                n_errors++;
                $display("FAIL access_phase: got %h expected %h",
                         {busy, bus.ack1, bus.ack0, ram_load, ram_sel, ram_in},
                         {1'b1, 1'b0, 1'b0, c.we, c.addr, c.data});
            end
            @(posedge clk); @(negedge clk);
            exp_last = w;
            if (c.we) ref_mem[c.addr] = c.data;
            else if (w) exp_rdata1 = ref_mem[c.addr];
            else exp_rdata0 = ref_mem[c.addr];
            n_checks++;
            if ({busy, bus.ack1, bus.ack0, ram_load, bus.rdata0, bus.rdata1} !== {1'b1, w, ~w, 1'b0, exp_rdata0, exp_rdata1}) begin
                n_errors++;
                $display("FAIL done_phase: got %h expected %h",
                         {busy, bus.ack1, bus.ack0, ram_load, bus.rdata0, bus.rdata1},
                         {1'b1, w, ~w, 1'b0, exp_rdata0, exp_rdata1});
            end
            grants.push_back(bus.ack1 ? 1 : 0);
            if (w) void'(q1.pop_front());
            else void'(q0.pop_front());
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({busy, bus.ack1, bus.ack0, ram_load, ram_sel, ram_in} !== {4'b0000, c.addr, c.data}) begin
                n_errors++;
                $display("FAIL idle_phase: got %h expected %h",
                         {busy, bus.ack1, bus.ack0, ram_load, ram_sel, ram_in}, {4'b0000, c.addr, c.data});
            end
        end
    endtask

    task automatic test_reset();
        logic [60:0] obs;
        #3;
        obs = {busy, ram_load, bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, ram_sel, ram_in};
        n_checks++;
        if (obs !== 61'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 61'd0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_rdata0 = 16'h0000;
        exp_rdata1 = 16'h0000;
        exp_last   = 1'b1;
    endtask

    task automatic test_write_read_p0();
        grants.delete();
        q0.push_back(mk(1'b1, 0, 16'hC0DE));
        q0.push_back(mk(1'b0, 0, 0));
        run_queues();
        n_checks++;
        if (bus.rdata0 !== 16'hC0DE) begin
            n_errors++;
            $display("FAIL p0_readback: got %h expected %h", bus.rdata0, 16'hC0DE);
        end
    endtask

    task automatic test_port1();
        logic [DW-1:0] r0_before;
        r0_before = bus.rdata0;
        q1.push_back(mk(1'b1, 128, 16'hDEAF));
        q1.push_back(mk(1'b1, 511, 16'hF00D));
        q1.push_back(mk(1'b0, 128, 0));
        q1.push_back(mk(1'b0, 511, 0));
        run_queues();
        n_checks++;
        if ({bus.rdata1, bus.rdata0} !== {16'hF00D, r0_before}) begin
            n_errors++;
            $display("FAIL p1_readback: got %h expected %h", {bus.rdata1, bus.rdata0}, {16'hF00D, r0_before});
        end
    endtask

    task automatic test_sim_reads();
        grants.delete();
        q0.push_back(mk(1'b0, 0, 0));
        q1.push_back(mk(1'b0, 511, 0));
        run_queues();
        n_checks++;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
            n_errors++;
            $display("FAIL sim_reads_order: got %p expected '{0,1}", grants);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6];
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(i[0], 16 + i, $urandom));
            q1.push_back(mk(~i[0], 32 + i, $urandom));
        end
        run_queues();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (grants.size() != 6 || grants[i] != exp_order[i]) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got %p expected %p", i, grants, exp_order);
            end
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 511 : $urandom_range(0, 7);
            q0.push_back(mk($urandom_range(0, 1), a, $urandom));
            a = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 7);
            q1.push_back(mk($urandom_range(0, 1), a, $urandom));
        end
        run_queues();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, ram_load, bus.ack0, bus.ack1} !== 4'b0000) begin
                n_errors++;
                $display("FAIL idle[%0d]: got %b expected %b", i, {busy, ram_load, bus.ack0, bus.ack1}, 4'b0000);
            end
        end
    endtask

    task automatic test_reset_during_write();
        logic [60:0] obs;
        q0.push_back(mk(1'b1, 5, 16'h1234));
        run_queues();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 9'd5; bus.wdata0 = 16'hBEEF;
        @(posedge clk); #2;
        n_checks++;
        if ({busy, ram_load} !== 2'b11) begin
            n_errors++;
            $display("FAIL rst_access_entry: got %b expected %b", {busy, ram_load}, 2'b11);
        end
        rst_n = 1'b0;
        #1;
        obs = {busy, ram_load, bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, ram_sel, ram_in};
        n_checks++;
        if (obs !== 61'd0) begin
            n_errors++;
            $display("FAIL rst_mid_access: got %h expected %h", obs, 61'd0);
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_rdata0 = 16'h0000;
        exp_rdata1 = 16'h0000;
        exp_last   = 1'b1;
        n_checks++;
        if ({mem[5], bus.ack0} !== {ref_mem[5], 1'b0}) begin
            n_errors++;
            $display("FAIL rst_no_commit: got %h expected %h", {mem[5], bus.ack0}, {ref_mem[5], 1'b0});
        end
        // after reset port 0 should again win the first tie
        grants.delete();
        q0.push_back(mk(1'b0, 5, 0));
        q1.push_back(mk(1'b0, 6, 0));
        run_queues();
        n_checks++;
        if (grants.size() != 2 || grants[0] != 0) begin
            n_errors++;
            $display("FAIL rst_first_tie: got %p expected first 0", grants);
        end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_read_p0();
        test_port1();
        test_sim_reads();
        test_round_robin();
        test_random();
        test_idle();
        test_reset_during_write();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram512_arbiter.md
# ram512_arbiter

Two-port arbiter and sequencer for a single-port 512 x 16 RAM. Two requesters (CPU data port and loader/DMA port) issue independent read/write commands with a req/ack handshake; the arbiter grants one at a time, drives the RAM select/data/load lines, and returns read data on a registered per-port bus. It sits between the requesters and the RAM and is the only driver of the RAM's input lines.

## Interface
- AW, 9, address width; RAM depth is 2**AW.
- DW, 16, data width.
- clk  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request; held high until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  AW  word address; stable while req is high.
- wdata0 / wdata1  in  DW  write data; stable while req is high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DW  registered read data; valid from the ack cycle until the next read completes on that port.
- ram_sel  out  AW  RAM address.
- ram_in  out  DW  RAM write data.
- ram_load  out  1  RAM write enable.
- ram_out  in  DW  RAM combinational read data.
- busy  out  1  high in the ACCESS and DONE states.

## Operation
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. Every access costs exactly 3 cycles, and no state is ever skipped.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata and its port id into command registers, update last_grant, and go to ACCESS.
- Arbitration with exactly one request: grant that port.
- Arbitration with both requests (default): round-robin; grant the port that is not last_grant. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS:
  - ram_sel = addr_q and ram_in = wdata_q.
  - ram_load = we_q, decoded combinationally from the state, so reset kills it immediately.
  - At the closing edge:
    - a write commits in the RAM;
    - for a read, ram_out is captured into the granted port's rdata;
    - the FSM goes to DONE.
- DONE:
  - ack for the granted port is high for this one cycle.
  - No arbitration takes place.
  - The FSM goes to IDLE.
- Requester rule: after ack, either drop req or present a new command before the next edge. The IDLE cycle after DONE samples the updated value, so a request is never served twice.
- rdata of the non-granted port is untouched. A write leaves the granted port's rdata unchanged.
- Outside ACCESS:
  - ram_load = 0;
  - ram_sel and ram_in hold their last driven values.
- Reset (asynchronous, any state):
  - state = IDLE, ack0/1 = 0, rdata0/1 = 0, ram_sel = 0, ram_in = 0, ram_load = 0, busy = 0, last_grant = 1.
  - An in-flight access is dropped without an ack. A write that has not reached its ACCESS closing edge does not commit.
- A req that falls before its ack (protocol violation) does not abort an access already granted; the ack is still issued.

## Timing
- Request is high at IDLE edge E0. ACCESS is the cycle after E0, and ack plus valid rdata appear in the following cycle (E0+2).
- Maximum throughput is one access per 3 cycles. Two ports that both stay asserted alternate as 0, 1, 0, 1, ...
- The read path is combinational through the RAM: ram_sel is valid from the start of ACCESS, and ram_out is sampled at the end of ACCESS.
- All outputs are registered except ram_load and busy, which decode the state register.

## Configuration
- RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie, and last_grant is ignored (still updated but unused).
- Undefined (default): round-robin as described above.

## Structure
- Package ram_arb_pkg holds:
  - the state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - default AW/DW constants;
  - port-id constants P0/P1.
- Sub-module ram_arb_pick2: combinational two-way picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
  - Contains the RAM_ARB_FIXED_PRIO_EN switch.
- The top level holds the FSM, command registers, rdata registers and the RAM drive.

## Test plan
- Single write, then read on port 0: write C0DE to address 0 with ack0 at E0+2, then read address 0 -> rdata0 = C0DE at ack0, ack1 never asserted.
- Port 1 writes DEAF to address 128 and F00D to address 511, then reads both back -> rdata1 = DEAF, then F00D; rdata0 unchanged.
- Simultaneous reads from reset, port 0 reading address 0 and port 1 reading address 511 -> ack0 first, ack1 three cycles later; with RAM_ARB_FIXED_PRIO_EN and port 0 re-requesting continuously, port 1 is starved.
- Both ports hold req for 6 accesses -> grant order 0, 1, 0, 1, 0, 1, with ram_load high only in ACCESS cycles of writes.
- Assert rst_n low during the ACCESS of a write of BEEF to address 5 -> ram_load drops immediately, no ack, mem[5] keeps its old value, all outputs read 0.
- Idle with no req for 10 cycles -> busy = 0, ram_load = 0, acks = 0.
